mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port, 1-cycle-latency memory: data wins,
// except that a fetch denied MAX_WAIT cycles in a row takes the next slot.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2,
    D_WR  = 2'd3
  } resp_st_t;

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  resp_st_t   resp_st_q, resp_st_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       if_win, d_win;

  // Grants are combinational and forced low while reset is held.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!reset) begin
      if_win = bus.if_req && (!bus.d_req || (wait_cnt_q == MAX_WAIT_C));
      d_win  = bus.d_req && !if_win;
    end
  end

  always_comb begin
    bus.if_gnt    = if_win;
    bus.d_gnt     = d_win;
    bus.mem_en    = if_win | d_win;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (if_win) begin
      bus.mem_addr = bus.if_addr;
    end else if (d_win) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = 3'd0;
    if (bus.if_req && !if_win) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 3'd1;
    end

    resp_st_d = NONE;
    if (if_win) begin
      resp_st_d = IF_RD;
    end else if (d_win) begin
      resp_st_d = bus.d_we ? D_WR : D_RD;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      resp_st_q  <= NONE;
      wait_cnt_q <= 3'd0;
    end else begin
      resp_st_q  <= resp_st_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    bus.if_valid = (resp_st_q == IF_RD);
    bus.d_valid  = (resp_st_q == D_RD) || (resp_st_q == D_WR);
    bus.if_rdata = (resp_st_q == IF_RD) ? bus.mem_rdata : 32'h0;
    bus.d_rdata  = (resp_st_q == D_RD)  ? bus.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration model plus response scoreboard
// against a behavioural 1-cycle synchronous memory.
module tb_mem_arbiter;
  localparam int unsigned MAX_WAIT = 3;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge CLOCK_50) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  int unsigned tb_wait = 0;
  logic [15:0] if_pat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive requests just after the edge, check before the next edge.
  task automatic cycle(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic rst_v);
    logic        e_if, e_d;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    @(posedge CLOCK_50);
    #1;
    bus.if_req  = ireq;
    bus.if_addr = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
    reset       = rst_v;
    #3;
    if (rst_v) begin
      exp_if.delete();
      exp_d.delete();
    end

    chk("if_valid", bus.if_valid, (exp_if.size() != 0));
    if (exp_if.size() != 0) chk("if_rdata", bus.if_rdata, exp_if.pop_front());
    else                    chk("if_rdata_idle", bus.if_rdata, 32'h0);
    chk("d_valid", bus.d_valid, (exp_d.size() != 0));
    if (exp_d.size() != 0)  chk("d_rdata", bus.d_rdata, exp_d.pop_front());
    else                    chk("d_rdata_idle", bus.d_rdata, 32'h0);

    e_if    = !rst_v && ireq && (!dreq || tb_wait == MAX_WAIT);
    e_d     = !rst_v && dreq && !e_if;
    e_addr  = e_if ? iaddr : (e_d ? daddr : 32'h0);
    e_we    = e_d && dwe;
    e_wdata = (e_d && !e_if) ? dwdata : 32'h0;
    chk("if_gnt", bus.if_gnt, e_if);
    chk("d_gnt", bus.d_gnt, e_d);
    chk("mem_en", bus.mem_en, e_if | e_d);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    if_pat = {if_pat[14:0], bus.if_gnt};

    if (e_if) exp_if.push_back(ref_mem[iaddr[9:2]]);
    if (e_d) begin
      if (dwe) begin
        exp_d.push_back(32'h0);
        ref_mem[daddr[9:2]] = dwdata;
      end else begin
        exp_d.push_back(ref_mem[daddr[9:2]]);
      end
    end

    if (rst_v || !ireq || e_if) tb_wait = 0;
    else if (tb_wait < MAX_WAIT) tb_wait++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    mem[8'h04]     = 32'hDEAD_BEEF;
    ref_mem[8'h04] = 32'hDEAD_BEEF;
    bus.mem_rdata  = 32'h0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

    // Requests held high under reset must not reach the memory.
    cycle(1'b1, 32'h10, 1'b1, 1'b1, 32'h44, 32'h5555, 1'b1);
    cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h44, 32'h5555, 1'b1);
    idle(1);

    // Fetch 0x10 -> DEADBEEF.
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);
    chk("deadbeef_ref", ref_mem[8'h04], 32'hDEAD_BEEF);

    // Store 0x1234 to 0x40, then load it back.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    idle(1);
    chk("store_ref", ref_mem[8'h10], 32'h0000_1234);

    // Sustained contention: fetch wins every fourth cycle.
    if_pat = 16'h0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    chk("contention_pattern", {16'h0, if_pat[11:0]}, 32'h0000_0111);
    idle(1);

    // Back-to-back fetches.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);

    // Reset right after a load grant drops the response.
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    cycle(1'b1, 32'h30, 1'b1, 1'b1, 32'h50, 32'hBAD0, 1'b1);
    idle(3);

    // Withdrawn fetch clears the wait count: data wins three more cycles after re-request.
    cycle(1'b1, 32'h24, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0);
    cycle(1'b1, 32'h24, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h8C, 32'h0, 1'b0);
    if_pat = 16'h0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h28, 1'b1, 1'b1, 32'h90 + 32'(4*i), 32'h7700 + 32'(i), 1'b0);
    chk("withdraw_pattern", {28'h0, if_pat[3:0]}, 32'h1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), {22'h0, 8'($urandom), 2'b00},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {22'h0, 8'($urandom), 2'b00}, $urandom, 1'b0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
